// File: rtl/tpu_apb_cfg.sv
// tpu_apb_cfg: APB slave holding the TPU run-control and stage configuration.
// A three-state APB tracker qualifies each access; writes commit and reads are
// captured on the edge that ends a qualified ACCESS cycle. The STDN register
// arbitrates the software start request against the datapath completion pulse.
module tpu_apb_cfg #(
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32,
  parameter int DWIDTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_ADDRWIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [REG_DATAWIDTH-1:0] PWDATA,
  output logic [REG_DATAWIDTH-1:0] PRDATA,
  output logic                     PREADY,
  output logic                     enable_matmul,
  output logic                     enable_norm,
  output logic                     enable_activation,
  output logic                     enable_pool,
  output logic [DWIDTH-1:0]        mean,
  output logic [DWIDTH-1:0]        inv_var,
  output logic                     start_tpu,
  input  logic                     done_tpu
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [REG_ADDRWIDTH-1:0] ADDR_STDN    = REG_ADDRWIDTH'('h00);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_ENABLES = REG_ADDRWIDTH'('h20);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_MEAN    = REG_ADDRWIDTH'('h28);
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_INV_VAR = REG_ADDRWIDTH'('h2C);

  apb_state_e               state_q, state_d;
  logic                     start_q, start_d;
  logic                     done_q, done_d;
  logic [3:0]               en_q, en_d;
  logic [DWIDTH-1:0]        mean_q, mean_d;
  logic [DWIDTH-1:0]        inv_var_q, inv_var_d;
  logic [REG_DATAWIDTH-1:0] prdata_q, prdata_d;
  logic [REG_DATAWIDTH-1:0] rdata;

  logic access_ok;
  logic wr_commit;
  logic rd_commit;
  logic stdn_wr;
  logic start_req;
  logic done_evt;

  // Only a few write-data bits reach registers; the rest are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^PWDATA;

  // A transfer completes only in ACCESS with the bus still driving select and enable.
  assign access_ok = (state_q == ACCESS) && PSEL && PENABLE;
  assign PREADY    = access_ok;
  assign wr_commit = access_ok && PWRITE;
  assign rd_commit = access_ok && !PWRITE;

  // STDN arbitration terms: a start only counts when idle, and completion is
  // honoured while running or when it coincides with a start request.
  assign stdn_wr   = wr_commit && (PADDR == ADDR_STDN);
  assign start_req = stdn_wr && PWDATA[0] && !start_q;
  assign done_evt  = done_tpu && (start_q || start_req);

  // APB phase tracker; dropping PSEL always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!PSEL) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!PENABLE) state_d = SETUP;
        SETUP:   if (PENABLE)  state_d = ACCESS;
        ACCESS:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Read-data mux for the currently addressed register; unused bits read 0.
  always_comb begin
    rdata = '0;
    unique case (PADDR)
      ADDR_STDN: begin
        rdata[0]               = start_q;
        rdata[REG_DATAWIDTH-1] = done_q;
      end
      ADDR_ENABLES: rdata[3:0]        = en_q;
      ADDR_MEAN:    rdata[DWIDTH-1:0] = mean_q;
      ADDR_INV_VAR: rdata[DWIDTH-1:0] = inv_var_q;
      default:      rdata             = '0;
    endcase
  end

  // Register next-state: completion outranks any STDN write on the same edge.
  always_comb begin
    start_d   = start_q;
    done_d    = done_q;
    en_d      = en_q;
    mean_d    = mean_q;
    inv_var_d = inv_var_q;
    prdata_d  = prdata_q;

    if (done_evt) begin
      start_d = 1'b0;
      done_d  = 1'b1;
    end else if (stdn_wr) begin
      if (PWDATA[0]) begin
        if (!start_q) begin
          start_d = 1'b1;
          done_d  = 1'b0;
        end
      end else begin
        start_d = 1'b0;
      end
    end

    if (wr_commit) begin
      unique case (PADDR)
        ADDR_ENABLES: en_d      = PWDATA[3:0];
        ADDR_MEAN:    mean_d    = PWDATA[DWIDTH-1:0];
        ADDR_INV_VAR: inv_var_d = PWDATA[DWIDTH-1:0];
        default:      en_d      = en_q;
      endcase
    end

    if (rd_commit) begin
      prdata_d = rdata;
    end
  end

  // State and register update; reset wins over any in-flight transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= '0;
      mean_q    <= '0;
      inv_var_q <= '0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      done_q    <= done_d;
      en_q      <= en_d;
      mean_q    <= mean_d;
      inv_var_q <= inv_var_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PRDATA            = prdata_q;
  assign start_tpu         = start_q;
  assign enable_matmul     = en_q[0];
  assign enable_norm       = en_q[1];
  assign enable_activation = en_q[2];
  assign enable_pool       = en_q[3];
  assign mean              = mean_q;
  assign inv_var           = inv_var_q;

endmodule

// File: tb/tb_tpu_apb_cfg.sv
// Bench for tpu_apb_cfg: APB reads push their expected data into a scoreboard
// queue; a monitor pops and compares when the DUT completes each read.
module tb_tpu_apb_cfg;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        enable_matmul, enable_norm, enable_activation, enable_pool;
  logic [7:0]  mean, inv_var;
  logic        start_tpu;
  logic        done_tpu;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  tpu_apb_cfg #(
    .REG_ADDRWIDTH(8),
    .REG_DATAWIDTH(32),
    .DWIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PADDR(PADDR),
    .PWRITE(PWRITE),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .enable_matmul(enable_matmul),
    .enable_norm(enable_norm),
    .enable_activation(enable_activation),
    .enable_pool(enable_pool),
    .mean(mean),
    .inv_var(inv_var),
    .start_tpu(start_tpu),
    .done_tpu(done_tpu)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] enables();
    return {enable_pool, enable_activation, enable_norm, enable_matmul};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (PREADY !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq("pready", {31'd0, PREADY}, 32'd1);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input bit pulse_done = 1'b0);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    wait_ready();
    if (pulse_done) done_tpu = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; done_tpu = 1'b0;
  endtask

  task automatic apb_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_done_tpu();
    @(posedge clk); #1;
    done_tpu = 1'b1;
    @(posedge clk); #1;
    done_tpu = 1'b0;
  endtask

  // Read monitor: a read completing in this cycle is compared just after the edge.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (PREADY === 1'b1 && PWRITE === 1'b0 && reset === 1'b0) begin
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
          chk_eq("sb_unexpected_read", PRDATA, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk_eq(e.tag, PRDATA, e.exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; PADDR = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    PWDATA = '0; done_tpu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_start", {31'd0, start_tpu}, 32'd0);
    chk_eq("rst_en", {28'd0, enables()}, 32'd0);
    chk_eq("rst_mean", {24'd0, mean}, 32'd0);
    chk_eq("rst_inv_var", {24'd0, inv_var}, 32'd0);
    chk_eq("rst_prdata", PRDATA, 32'd0);
    chk_eq("rst_pready", {31'd0, PREADY}, 32'd0);
    reset = 1'b0;

    // Config write / readback
    apb_write(8'h20, 32'h0000_000f);
    chk_eq("en_all", {28'd0, enables()}, 32'hf);
    apb_read("rd_en_f", 8'h20, 32'h0000_000f);
    apb_write(8'h20, 32'h0000_000d);
    chk_eq("en_norm_off", {31'd0, enable_norm}, 32'd0);
    chk_eq("en_d", {28'd0, enables()}, 32'hd);
    chk_eq("prdata_hold", PRDATA, 32'h0000_000f);

    // Normalization constants and unmapped addresses
    apb_write(8'h28, 32'h0000_0001);
    apb_write(8'h2C, 32'h0000_0001);
    chk_eq("mean_1", {24'd0, mean}, 32'h01);
    chk_eq("inv_var_1", {24'd0, inv_var}, 32'h01);
    apb_read("rd_mean", 8'h28, 32'h0000_0001);
    apb_read("rd_inv_var", 8'h2C, 32'h0000_0001);
    apb_read("rd_unmapped", 8'h44, 32'h0000_0000);
    apb_write(8'h44, 32'hffff_ffff);
    apb_read("rd_en_after_unmapped", 8'h20, 32'h0000_000d);
    apb_write(8'h28, 32'hffff_ff5a);
    chk_eq("mean_5a", {24'd0, mean}, 32'h5a);
    apb_read("rd_mean_5a", 8'h28, 32'h0000_005a);

    // Start / done handshake, busy start, config while busy
    apb_write(8'h00, 32'h0000_0001);
    chk_eq("start_set", {31'd0, start_tpu}, 32'd1);
    apb_read("rd_stdn_busy", 8'h00, 32'h0000_0001);
    apb_write(8'h20, 32'h0000_000f);
    chk_eq("en_while_busy", {28'd0, enables()}, 32'hf);
    apb_write(8'h00, 32'h0000_0001);
    chk_eq("busy_start", {31'd0, start_tpu}, 32'd1);
    pulse_done_tpu();
    chk_eq("done_clears_start", {31'd0, start_tpu}, 32'd0);
    apb_read("rd_stdn_done", 8'h00, 32'h8000_0000);

    // Software stop keeps done; spurious completion ignored
    apb_write(8'h00, 32'h0000_0000);
    apb_read("rd_stop_keeps_done", 8'h00, 32'h8000_0000);
    apb_write(8'h00, 32'h0000_0001);
    apb_read("rd_restart", 8'h00, 32'h0000_0001);
    apb_write(8'h00, 32'h0000_0000);
    chk_eq("sw_stop", {31'd0, start_tpu}, 32'd0);
    pulse_done_tpu();
    chk_eq("spurious_done_start", {31'd0, start_tpu}, 32'd0);
    apb_read("rd_spurious_done", 8'h00, 32'h0000_0000);

    // Completion landing on the same edge as a start write
    apb_write(8'h00, 32'h0000_0001, 1'b1);
    chk_eq("collide_start", {31'd0, start_tpu}, 32'd0);
    apb_read("rd_collide", 8'h00, 32'h8000_0000);

    // Protocol abuse: enable without setup
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h28; PWDATA = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_eq("no_setup_pready", {31'd0, PREADY}, 32'd0);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    chk_eq("no_setup_mean", {24'd0, mean}, 32'h5a);

    // Protocol abuse: PSEL dropped in SETUP
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h28; PWDATA = 32'h77;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b1;
    @(posedge clk); #1;
    chk_eq("drop_psel_pready", {31'd0, PREADY}, 32'd0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    chk_eq("drop_psel_mean", {24'd0, mean}, 32'h5a);

    // Reset mid-run with a transfer in flight
    apb_write(8'h00, 32'h0000_0001);
    chk_eq("pre_rst_start", {31'd0, start_tpu}, 32'd1);
    chk_eq("pre_rst_en", {28'd0, enables()}, 32'hf);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h28; PWDATA = 32'h33;
    @(posedge clk); #1;
    PENABLE = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_eq("rst_abort_pready", {31'd0, PREADY}, 32'd0);
    @(posedge clk); #1;
    chk_eq("rst_abort_mean", {24'd0, mean}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    chk_eq("mid_rst_start", {31'd0, start_tpu}, 32'd0);
    chk_eq("mid_rst_en", {28'd0, enables()}, 32'd0);
    chk_eq("mid_rst_inv_var", {24'd0, inv_var}, 32'd0);
    chk_eq("mid_rst_prdata", PRDATA, 32'd0);
    apb_read("rd_stdn_after_rst", 8'h00, 32'h0000_0000);

    repeat (3) @(posedge clk);
    #1;
    chk_eq("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tpu_apb_cfg.md
TPU_APB_CFG -- requirements
Module: tpu_apb_cfg

Interface
REQ-001 Parameter: REG_ADDRWIDTH, default 8, APB address width.
REQ-002 Parameter: REG_DATAWIDTH, default 32, APB data width.
REQ-003 Parameter: DWIDTH, default 8, width of the mean and inv_var fields.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: PADDR  input  REG_ADDRWIDTH  APB byte address.
REQ-007 Port: PWRITE  input  1  APB direction; 1 = write.
REQ-008 Port: PSEL  input  1  APB select.
REQ-009 Port: PENABLE  input  1  APB access-phase strobe.
REQ-010 Port: PWDATA  input  REG_DATAWIDTH  APB write data.
REQ-011 Port: PRDATA  output  REG_DATAWIDTH  registered APB read data.
REQ-012 Port: PREADY  output  1  transfer-complete strobe.
REQ-013 Port: enable_matmul, enable_norm, enable_activation, enable_pool  output  1 each  stage enables.
REQ-014 Port: mean, inv_var  output  DWIDTH each  normalization constants.
REQ-015 Port: start_tpu  output  1  run request, held high while the TPU is busy.
REQ-016 Port: done_tpu  input  1  single-cycle completion pulse from the datapath.

Function
REQ-017 Register map:
- 0x00 STDN: bit0 start (R/W), bit31 done (RO).
- 0x20 ENABLES: bit0 matmul, bit1 norm, bit2 activation, bit3 pool.
- 0x28 MEAN: bits [DWIDTH-1:0].
- 0x2C INV_VAR: bits [DWIDTH-1:0].
- Unused bits read as 0.
REQ-018 APB FSM states IDLE, SETUP, ACCESS:
- IDLE -> SETUP when PSEL=1 and PENABLE=0.
- SETUP -> ACCESS when PSEL=1 and PENABLE=1.
- ACCESS -> IDLE on the next edge.
- Any state -> IDLE whenever PSEL=0.
REQ-019 PREADY shall be 1 combinationally only while in ACCESS with PSEL=1 and PENABLE=1; it is 0 otherwise.
REQ-020 Write commit: a write takes effect at the clock edge ending a valid ACCESS cycle with PWRITE=1; zero wait states.
REQ-021 Read capture: PRDATA is loaded at the edge ending a valid ACCESS cycle with PWRITE=0, and holds that value until the next read commit.
REQ-022 Unmapped address: a write is discarded and a read returns 0; both still complete with PREADY.
REQ-023 PENABLE=1 seen in IDLE (no SETUP phase) shall neither commit a write nor capture a read.
REQ-024 Start request: writing STDN with bit0=1 while start_tpu=0 sets start_tpu=1 and clears done on the same edge.
REQ-025 Stop by software: writing STDN with bit0=0 clears start_tpu and leaves done unchanged.
REQ-026 Start while busy: writing bit0=1 while start_tpu=1 has no effect.
REQ-027 Completion: done_tpu=1 while start_tpu=1 clears start_tpu and sets done on the next edge.
REQ-028 Spurious completion: done_tpu while start_tpu=0 is ignored.
REQ-029 Simultaneous events: if done_tpu and an STDN start write land on the same edge, done_tpu takes priority; start_tpu becomes 0 and done becomes 1.
REQ-030 Read-back of STDN returns {done, 30'b0, start_tpu} as sampled at the capture edge.
REQ-031 Config writes to ENABLES, MEAN and INV_VAR are accepted even while start_tpu=1 and take effect immediately.

Reset
REQ-032 When reset=1 at an edge, all of the following go to 0 and the FSM goes to IDLE:
- PRDATA and done;
- start_tpu;
- all four enables;
- mean and inv_var.
REQ-033 Reset asserted mid-transfer shall abort the transfer with no register update.

Verification
REQ-034 Config write/readback: write 0x20=0x0000000f, then read 0x20 -> PRDATA=0x0000000f and all four enables=1; write 0x0000000d -> enable_norm=0.
REQ-035 Constants: write 0x28=0x01 and 0x2C=0x01 -> mean=8'h01, inv_var=8'h01; read 0x44 -> PRDATA=0 with PREADY pulsed.
REQ-036 Start/done handshake: write 0x00=1 -> start_tpu=1 and STDN reads 0x00000001; pulse done_tpu -> start_tpu=0 and STDN reads 0x80000000.
REQ-037 Collisions and busy start:
- done_tpu pulse on the same edge as a start write -> start_tpu=0, done=1.
- Second start write while busy -> no change.
REQ-038 Protocol abuse: PENABLE without a prior SETUP phase -> no commit and PREADY=0; drop PSEL in SETUP -> FSM returns to IDLE and no write occurs.
REQ-039 Reset mid-run: with start_tpu=1 and enables=0xf, assert reset for one cycle -> all outputs 0 and STDN reads 0x00000000.
